// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with bubble insertion, halt latch and bubble counter
//
// Purpose: holds one decoded instruction between decode and execute. Loads on
// every enabled edge, inserts a bubble on stall/flush or once a halt has passed,
// and freezes entirely when i_enable is low.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_enable                 pipeline advance; low holds every register
//   i_stall, i_flush         hazard requests, each inserts a counted bubble
//   i_signals                decode control bundle (bit 0 = halt_e)
//   i_pc8 .. i_imm_ext       data words from decode
//   i_rs, i_rt, i_rd         register addresses
//   i_shamt, i_funct         shift amount and function field
//   o_*                      registered copies of the above
//   o_valid                  stage holds a real instruction
//   o_halt                   halt_e of the held instruction
//   o_halted                 sticky: a halt has entered this stage
//   o_bubble_cnt             saturating count of stall/flush bubbles
module id_ex_reg #(
   parameter int NB_SGN  = 20,
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 5,
   parameter int NB_CNT  = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_stall,
   input  logic               i_flush,
   input  logic [NB_SGN-1:0]  i_signals,
   input  logic [NB_DATA-1:0] i_pc8,
   input  logic [NB_DATA-1:0] i_rs_data,
   input  logic [NB_DATA-1:0] i_rt_data,
   input  logic [NB_DATA-1:0] i_imm_ext,
   input  logic [NB_ADDR-1:0] i_rs,
   input  logic [NB_ADDR-1:0] i_rt,
   input  logic [NB_ADDR-1:0] i_rd,
   input  logic [4:0]         i_shamt,
   input  logic [5:0]         i_funct,
   output logic [NB_SGN-1:0]  o_signals,
   output logic [NB_DATA-1:0] o_pc8,
   output logic [NB_DATA-1:0] o_rs_data,
   output logic [NB_DATA-1:0] o_rt_data,
   output logic [NB_DATA-1:0] o_imm_ext,
   output logic [NB_ADDR-1:0] o_rs,
   output logic [NB_ADDR-1:0] o_rt,
   output logic [NB_ADDR-1:0] o_rd,
   output logic [4:0]         o_shamt,
   output logic [5:0]         o_funct,
   output logic               o_valid,
   output logic               o_halt,
   output logic               o_halted,
   output logic [NB_CNT-1:0]  o_bubble_cnt
);

   logic hazard;
   logic bubble;
   logic cnt_full;

   assign hazard   = i_stall | i_flush;
   // Once halted, the stage drains forever with bubbles until reset.
   assign bubble   = o_halted | hazard;
   assign cnt_full = &o_bubble_cnt;

   // o_halt is taken from the registered bundle, so it stays register-driven.
   assign o_halt = o_signals[0];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_signals    <= '0;
         o_pc8        <= '0;
         o_rs_data    <= '0;
         o_rt_data    <= '0;
         o_imm_ext    <= '0;
         o_rs         <= '0;
         o_rt         <= '0;
         o_rd         <= '0;
         o_shamt      <= '0;
         o_funct      <= '0;
         o_valid      <= 1'b0;
         o_halted     <= 1'b0;
         o_bubble_cnt <= '0;
      end else if (i_enable) begin
         if (bubble) begin
            o_signals <= '0;
            o_pc8     <= '0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm_ext <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_shamt   <= '0;
            o_funct   <= '0;
            o_valid   <= 1'b0;
            // Post-halt drain bubbles are not hazard bubbles and are not counted.
            if (!o_halted && !cnt_full)
               o_bubble_cnt <= o_bubble_cnt + 1'b1;
         end else begin
            o_signals <= i_signals;
            o_pc8     <= i_pc8;
            o_rs_data <= i_rs_data;
            o_rt_data <= i_rt_data;
            o_imm_ext <= i_imm_ext;
            o_rs      <= i_rs;
            o_rt      <= i_rt;
            o_rd      <= i_rd;
            o_shamt   <= i_shamt;
            o_funct   <= i_funct;
            o_valid   <= 1'b1;
            if (i_signals[0])
               o_halted <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - randomized self-checking bench for id_ex_reg against a behavioural model
module tb_id_ex_reg;

   localparam int NB_SGN  = 20;
   localparam int NB_DATA = 32;
   localparam int NB_ADDR = 5;
   localparam int NB_CNT  = 4;
   localparam int CNT_MAX = (1 << NB_CNT) - 1;

   logic               clk = 1'b0;
   logic               reset, enable, stall, flush;
   logic [NB_SGN-1:0]  signals;
   logic [NB_DATA-1:0] pc8, rs_data, rt_data, imm_ext;
   logic [NB_ADDR-1:0] rs, rt, rd;
   logic [4:0]         shamt;
   logic [5:0]         funct;

   logic [NB_SGN-1:0]  q_signals;
   logic [NB_DATA-1:0] q_pc8, q_rs_data, q_rt_data, q_imm_ext;
   logic [NB_ADDR-1:0] q_rs, q_rt, q_rd;
   logic [4:0]         q_shamt;
   logic [5:0]         q_funct;
   logic               q_valid, q_halt, q_halted;
   logic [NB_CNT-1:0]  q_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_ex_reg #(
      .NB_SGN(NB_SGN), .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_stall(stall), .i_flush(flush),
      .i_signals(signals), .i_pc8(pc8), .i_rs_data(rs_data), .i_rt_data(rt_data),
      .i_imm_ext(imm_ext), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_funct(funct),
      .o_signals(q_signals), .o_pc8(q_pc8), .o_rs_data(q_rs_data), .o_rt_data(q_rt_data),
      .o_imm_ext(q_imm_ext), .o_rs(q_rs), .o_rt(q_rt), .o_rd(q_rd), .o_shamt(q_shamt),
      .o_funct(q_funct), .o_valid(q_valid), .o_halt(q_halt), .o_halted(q_halted),
      .o_bubble_cnt(q_cnt)
   );

   // Behavioural model: the held instruction as a flat set of fields, a
   // halted flag and an integer bubble count.
   bit               m_known = 1'b0;
   logic [NB_SGN-1:0]  m_sig;
   logic [NB_DATA-1:0] m_pc8, m_rsd, m_rtd, m_imm;
   logic [NB_ADDR-1:0] m_rs, m_rt, m_rd;
   logic [4:0]         m_shamt;
   logic [5:0]         m_funct;
   bit               m_valid, m_halted;
   int               m_cnt;

   task automatic model_clear_instr();
      m_sig = '0; m_pc8 = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0; m_shamt = '0; m_funct = '0;
      m_valid = 1'b0;
   endtask

   always @(posedge clk) begin
      if (reset) begin
         model_clear_instr();
         m_halted = 1'b0;
         m_cnt    = 0;
         m_known  = 1'b1;
      end else if (enable && m_known) begin
         if (m_halted) begin
            model_clear_instr();
         end else if (stall || flush) begin
            model_clear_instr();
            m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
         end else begin
            m_sig = signals; m_pc8 = pc8; m_rsd = rs_data; m_rtd = rt_data; m_imm = imm_ext;
            m_rs = rs; m_rt = rt; m_rd = rd; m_shamt = shamt; m_funct = funct;
            m_valid = 1'b1;
            if (signals[0]) m_halted = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (m_known) begin
         n_vec++;
         chk("signals",  64'(q_signals), 64'(m_sig));
         chk("pc8",      64'(q_pc8),     64'(m_pc8));
         chk("rs_data",  64'(q_rs_data), 64'(m_rsd));
         chk("rt_data",  64'(q_rt_data), 64'(m_rtd));
         chk("imm_ext",  64'(q_imm_ext), 64'(m_imm));
         chk("rs",       64'(q_rs),      64'(m_rs));
         chk("rt",       64'(q_rt),      64'(m_rt));
         chk("rd",       64'(q_rd),      64'(m_rd));
         chk("shamt",    64'(q_shamt),   64'(m_shamt));
         chk("funct",    64'(q_funct),   64'(m_funct));
         chk("valid",    64'(q_valid),   64'(m_valid));
         chk("halt",     64'(q_halt),    64'(m_sig[0]));
         chk("halted",   64'(q_halted),  64'(m_halted));
         chk("bubble_cnt", 64'(q_cnt),   64'(m_cnt));
      end
   end

   task automatic rand_data();
      pc8 = $urandom; rs_data = $urandom; rt_data = $urandom; imm_ext = $urandom;
      rs = NB_ADDR'($urandom); rt = NB_ADDR'($urandom); rd = NB_ADDR'($urandom);
      shamt = 5'($urandom); funct = 6'($urandom);
   endtask

   // One edge with the given controls and random data; returns #1 after the edge.
   task automatic cyc(input logic r, input logic en, input logic st, input logic fl,
                      input logic [NB_SGN-1:0] sg);
      @(negedge clk);
      #1;
      reset = r; enable = en; stall = st; flush = fl; signals = sg;
      rand_data();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; stall = 1'b0; flush = 1'b0; signals = '0;
      rand_data();

      // Reset, even with enable low.
      cyc(1, 0, 1, 1, 20'hFFFFF);
      cyc(1, 1, 0, 0, 20'h01004);
      chk("pin_reset_valid", 64'(q_valid), 64'd0);
      chk("pin_reset_cnt", 64'(q_cnt), 64'd0);
      chk("pin_reset_sig", 64'(q_signals), 64'd0);

      // Plain load.
      @(negedge clk); #1;
      reset = 0; enable = 1; stall = 0; flush = 0; signals = 20'h04004;
      rand_data(); rs_data = 32'h12345678;
      @(posedge clk); #1;
      chk("pin_load_sig", 64'(q_signals), 64'h04004);
      chk("pin_load_rsd", 64'(q_rs_data), 64'h12345678);
      chk("pin_load_valid", 64'(q_valid), 64'd1);

      // Stall, then stall+flush together: two bubbles, two counts.
      cyc(0, 1, 1, 0, 20'h04004);
      chk("pin_stall_valid", 64'(q_valid), 64'd0);
      cyc(0, 1, 1, 1, 20'h04004);
      chk("pin_sf_sig", 64'(q_signals), 64'd0);
      chk("pin_sf_cnt", 64'(q_cnt), 64'd2);

      // Load then freeze three cycles with flush and churning inputs.
      @(negedge clk); #1;
      stall = 0; flush = 0; signals = 20'h01004;
      rand_data(); rs_data = 32'hCAFEF00D;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, NB_SGN'($urandom));
      chk("pin_freeze_sig", 64'(q_signals), 64'h01004);
      chk("pin_freeze_rsd", 64'(q_rs_data), 64'hCAFEF00D);
      chk("pin_freeze_cnt", 64'(q_cnt), 64'd2);

      // Randomized phase, occasional halts and resets.
      for (int i = 0; i < 400; i++) begin
         logic [NB_SGN-1:0] sg;
         sg = NB_SGN'($urandom);
         sg[0] = ($urandom_range(0, 29) == 0);
         cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < 85),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0), sg);
      end

      // Saturation: 20 consecutive stalls.
      cyc(1, 1, 0, 0, '0);
      for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 20'h01004);
      chk("pin_sat_cnt", 64'(q_cnt), 64'hF);

      // Halt: one stall first so the count is 1, then halt, then drain with stalls.
      cyc(1, 1, 0, 0, '0);
      cyc(0, 1, 1, 0, 20'h01004);
      cyc(0, 1, 0, 0, 20'h00001);
      chk("pin_halt_halt", 64'(q_halt), 64'd1);
      chk("pin_halt_valid", 64'(q_valid), 64'd1);
      chk("pin_halt_halted", 64'(q_halted), 64'd1);
      cyc(0, 1, 0, 0, 20'h01004);
      cyc(0, 1, 1, 1, 20'h01004);
      chk("pin_drain_sig", 64'(q_signals), 64'd0);
      chk("pin_drain_valid", 64'(q_valid), 64'd0);
      chk("pin_drain_halted", 64'(q_halted), 64'd1);
      chk("pin_drain_cnt", 64'(q_cnt), 64'd1);

      // Reset mid-halt, then a normal load.
      cyc(1, 1, 1, 0, 20'h01004);
      chk("pin_rst_halted", 64'(q_halted), 64'd0);
      chk("pin_rst_cnt", 64'(q_cnt), 64'd0);
      cyc(0, 1, 0, 0, 20'h01004);
      chk("pin_reload_valid", 64'(q_valid), 64'd1);
      chk("pin_reload_halted", 64'(q_halted), 64'd0);
      chk("pin_reload_sig", 64'(q_signals), 64'h01004);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter NB_SGN, default 20, width of control bundle from decode.
REQ-002 Parameter NB_DATA, default 32, width of register data, immediate and PC.
REQ-003 Parameter NB_ADDR, default 5, width of register-file addresses.
REQ-004 Parameter NB_CNT, default 16, width of bubble counter.
REQ-005 i_clk  in  1  single clock; all state updates on rising edge.
REQ-006 i_reset  in  1  reset, synchronous, active-high.
REQ-007 i_enable  in  1  pipeline advance (debug step); low freezes all state.
REQ-008 i_stall  in  1  load-use stall from hazard unit; inserts bubble.
REQ-009 i_flush  in  1  control-hazard flush; inserts bubble.
REQ-010 i_signals  in  NB_SGN  decode control bundle: 19 Jump, 18 JSel, 17 Branch, 16 IsBeq, 15 RegDst, 14 AluSrc, 13:10 AluOp, 9 JalSel, 8 MemRd, 7 MemWr, 6:4 BHW, 3 MemToReg, 2 RegWr, 1 IsJal, 0 halt_e.
REQ-011 i_pc8, i_rs_data, i_rt_data, i_imm_ext  in  NB_DATA each  PC+8, operands, sign-extended immediate.
REQ-012 i_rs, i_rt, i_rd  in  NB_ADDR each; i_shamt in 5; i_funct in 6.
REQ-013 o_signals  out  NB_SGN  registered bundle; o_pc8, o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd, o_shamt, o_funct registered copies.
REQ-014 o_valid  out  1  high when stage holds a real instruction.
REQ-015 o_halt  out  1  registered halt_e of held instruction (equals o_signals[0]).
REQ-016 o_halted  out  1  sticky: a halt has entered this stage.
REQ-017 o_bubble_cnt  out  NB_CNT  count of bubbles inserted.

Function
REQ-018 Update priority per edge SHALL be: i_reset > !i_enable (hold) > o_halted (bubble) > i_stall|i_flush (bubble) > load.
REQ-019 Load SHALL capture every input into its output register, set o_valid=1, latency one cycle.
REQ-020 Bubble SHALL force o_signals=0 and o_valid=0; data/address/shamt/funct registers SHALL load 0.
REQ-021 Hold (i_enable=0) SHALL keep all outputs and counter unchanged, ignoring i_stall, i_flush and i_signals.
REQ-022 Simultaneous i_stall and i_flush SHALL produce one bubble and one counter increment.
REQ-023 o_halted SHALL set on the edge that loads i_signals[0]=1 and stay high until reset; that halt instruction SHALL be held with o_valid=1 for exactly one cycle.
REQ-024 With o_halted=1 and i_enable=1, every edge SHALL insert a bubble regardless of inputs; these bubbles SHALL NOT increment o_bubble_cnt.
REQ-025 o_bubble_cnt SHALL increment by 1 per bubble inserted due to i_stall|i_flush with i_enable=1, saturating at 2^NB_CNT-1 (no wrap).
REQ-026 No combinational path from any input to any output.

Reset
REQ-027 On i_reset=1 at an edge, all outputs SHALL become 0 (o_valid=0, o_halted=0, o_bubble_cnt=0), regardless of i_enable.
REQ-028 Reset asserted mid-halt or mid-stall SHALL clear state fully; first edge after deassertion with i_enable=1 and no stall/flush SHALL load normally.

Verification
REQ-029 Load: i_signals=20'h04004 (AluSrc, RegWr), i_rs_data=32'h12345678, enable=1 -> next cycle o_signals=20'h04004, o_rs_data=32'h12345678, o_valid=1.
REQ-030 Stall/flush: i_stall=1 one cycle then i_flush=1 with i_stall=1 next cycle -> o_signals=0, o_valid=0 both cycles, o_bubble_cnt=2.
REQ-031 Freeze: i_enable=0 for 3 cycles with i_flush=1 and changing inputs -> all outputs and o_bubble_cnt unchanged.
REQ-032 Halt: load i_signals=20'h00001 -> o_halt=1, o_valid=1, o_halted=1 one cycle; following edges o_signals=0, o_valid=0, o_halted=1, counter unchanged despite valid ADDU bundle 20'h01004 on input.
REQ-033 Saturation: NB_CNT=4, 20 consecutive stalls -> o_bubble_cnt stops at 4'hF.
REQ-034 Reset mid-halt: o_halted=1, assert i_reset one cycle -> all outputs 0; next enabled load of 20'h01004 -> o_valid=1, o_halted=0.
